dbus_ctrl: RTL

Sequencing controller between the MEM-stage load/store datapath and the data bus (`dbus_req_t` / `dbus_resp_t`). It accepts one load or store command at a time and checks alignment. It builds a correctly sized, strobed and lane-shifted bus request, holds it until `data_ok`, then returns lane-extracted and sign/zero-extended load data. It also drives a stall signal back to the pipeline and supports flushing a command whose bus transaction is already in flight.

---
 rtl/dbus_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dbus_ctrl.sv
// MEM-stage data-bus sequencer: accepts one load/store, checks alignment, issues a
// lane-shifted strobed bus request, and returns extended load data or a fault.
package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_ctrl
    import dbus_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic        flush,
    output dbus_req_t   dreq,
    input  dbus_resp_t  dresp,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_misalign,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_FAULT} state_e;

    state_e      state_q, state_d;
    dbus_req_t   dreq_q, dreq_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [2:0]  off_q, off_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_misalign_q, resp_misalign_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;

    logic        misalign;
    logic [7:0]  strobe_base;
    logic [63:0] rdata_sh;
    logic [63:0] load_ext;
    logic        unused_addr_ok;

    // Completion is keyed on data_ok alone.
    assign unused_addr_ok = dresp.addr_ok;

    always_comb begin
        misalign    = 1'b0;
        strobe_base = 8'h01;
        case (req_size)
            2'd0: begin misalign = 1'b0;                  strobe_base = 8'h01; end
            2'd1: begin misalign = req_addr[0];           strobe_base = 8'h03; end
            2'd2: begin misalign = |req_addr[1:0];        strobe_base = 8'h0F; end
            default: begin misalign = |req_addr[2:0];     strobe_base = 8'hFF; end
        endcase
    end

    assign rdata_sh = dresp.data >> {off_q, 3'b000};

    always_comb begin
        load_ext = rdata_sh;
        case (size_q)
            2'd0: load_ext = unsigned_q ? {56'b0, rdata_sh[7:0]}
                                        : {{56{rdata_sh[7]}}, rdata_sh[7:0]};
            2'd1: load_ext = unsigned_q ? {48'b0, rdata_sh[15:0]}
                                        : {{48{rdata_sh[15]}}, rdata_sh[15:0]};
            2'd2: load_ext = unsigned_q ? {32'b0, rdata_sh[31:0]}
                                        : {{32{rdata_sh[31]}}, rdata_sh[31:0]};
            default: load_ext = rdata_sh;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        dreq_d          = dreq_q;
        write_d         = write_q;
        size_d          = size_q;
        unsigned_d      = unsigned_q;
        off_d           = off_q;
        resp_valid_d    = 1'b0;
        resp_misalign_d = 1'b0;
        resp_rdata_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    off_d      = req_addr[2:0];
                    if (misalign) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d       = S_BUSY;
                        dreq_d.valid  = 1'b1;
                        dreq_d.addr   = req_addr;
                        dreq_d.size   = {1'b0, req_size};
                        dreq_d.strobe = req_write ? (strobe_base << req_addr[2:0]) : 8'h00;
                        dreq_d.data   = req_write ? (req_wdata << {req_addr[2:0], 3'b000}) : 64'd0;
                    end
                end
            end
            S_BUSY: begin
                if (dresp.data_ok) begin
                    state_d      = S_IDLE;
                    dreq_d       = '0;
                    resp_valid_d = !flush;
                    resp_rdata_d = (flush || write_q) ? 64'd0 : load_ext;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            // The bus beat cannot be aborted, so the request stays up until it lands.
            S_DRAIN: begin
                if (dresp.data_ok) begin
                    state_d = S_IDLE;
                    dreq_d  = '0;
                end
            end
            S_FAULT: begin
                state_d         = S_IDLE;
                resp_valid_d    = !flush;
                resp_misalign_d = !flush;
            end
            default: begin
                state_d = S_IDLE;
                dreq_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            dreq_q          <= '0;
            write_q         <= 1'b0;
            size_q          <= 2'd0;
            unsigned_q      <= 1'b0;
            off_q           <= 3'd0;
            resp_valid_q    <= 1'b0;
            resp_misalign_q <= 1'b0;
            resp_rdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            dreq_q          <= dreq_d;
            write_q         <= write_d;
            size_q          <= size_d;
            unsigned_q      <= unsigned_d;
            off_q           <= off_d;
            resp_valid_q    <= resp_valid_d;
            resp_misalign_q <= resp_misalign_d;
            resp_rdata_q    <= resp_rdata_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign req_ready     = !busy;
    assign dreq          = dreq_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_misalign = resp_misalign_q;

endmodule
